// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//
// Parametrised core register file with a per-register pending-write
// scoreboard. Decode reads operands and issues instructions against it; the
// writeback stage completes results through the write ports. Each register
// carries a small saturating counter of outstanding writes, which drives the
// hazard flags (rd_busy, busy_vec) and the issue back-pressure (issue_stall).
//
// Ports:
//   clk            clock
//   reset_RF       synchronous active-high reset (clears data, counters, error)
//   init_R0        load R0 with init_R0_data this cycle (core launch path)
//   init_R0_data   R0 init value
//   rd_ptr         packed read addresses, port k at [k*PTR_W +: PTR_W]
//   rd_data        packed read data (combinational, bypassed from writes)
//   rd_busy        per read port: source still has a write outstanding
//                  after this cycle's completions
//   issue_valid    decode issues an instruction writing issue_dst
//   issue_dst      destination register of the issued instruction
//   issue_stall    issue refused: issue_dst counter saturated, no completion
//   wr_en          write port enables
//   wr_ptr         packed write addresses
//   wr_data        packed write data
//   busy_vec       registered per-register "pending != 0"
//   err_underflow  sticky: a write completed to a register with nothing pending
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 8,
  parameter int RD_PORTS  = 3,
  parameter int WR_PORTS  = 2,
  parameter int PEND_W    = 2,
  localparam int PTR_W    = $clog2(REG_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset_RF,
  input  logic                         init_R0,
  input  logic [DATA_W-1:0]            init_R0_data,
  input  logic [RD_PORTS*PTR_W-1:0]    rd_ptr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         issue_valid,
  input  logic [PTR_W-1:0]             issue_dst,
  output logic                         issue_stall,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*PTR_W-1:0]    wr_ptr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  output logic [REG_COUNT-1:0]         busy_vec,
  output logic                         err_underflow
);

  // Completion count per register needs to hold 0..WR_PORTS.
  localparam int CNT_W = $clog2(WR_PORTS + 1);
  // Working width for pending + issue - completions, wide enough for either
  // operand plus one carry bit so the underflow compare is exact.
  localparam int SUM_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_reg    [REG_COUNT];
  logic [PEND_W-1:0] pending_reg [REG_COUNT];
  logic [REG_COUNT-1:0] busy_vec_reg;
  logic err_underflow_reg;

  // ---------------------------------------------------------------------------
  // Per-register write resolution, completion count and counter next-state
  // ---------------------------------------------------------------------------
  logic [REG_COUNT-1:0] win_valid;
  logic [DATA_W-1:0]    win_data    [REG_COUNT];
  logic [CNT_W-1:0]     cnt         [REG_COUNT];
  logic [PEND_W-1:0]    pending_next[REG_COUNT];
  logic [REG_COUNT-1:0] underflow;
  logic                 issue_acc;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      logic              hit;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  count;
      logic              inc;
      logic [SUM_W-1:0]  sum;
      logic [PEND_W-1:0] nxt;
      logic              under;

      // Scan ports from highest to lowest so the lowest-index port wins.
      // Every enabled port that addresses this register counts as a
      // completion, even the ones whose data is discarded.
      always_comb begin
        hit   = 1'b0;
        data  = '0;
        count = '0;
        for (int p = WR_PORTS - 1; p >= 0; p--) begin
          if (wr_en[p] && (wr_ptr[p*PTR_W +: PTR_W] == PTR_W'(gi))) begin
            hit   = 1'b1;
            data  = wr_data[p*DATA_W +: DATA_W];
            count = count + CNT_W'(1);
          end
        end
        // The launch-time R0 load beats every write port but is not a
        // completion, so it leaves the count alone.
        if ((gi == 0) && init_R0) begin
          hit  = 1'b1;
          data = init_R0_data;
        end
      end

      // Counter update: add an accepted issue, remove completions, clamp at
      // zero and flag the underflow. Overflow cannot happen because a
      // saturated counter only accepts an issue when a completion arrives
      // in the same cycle.
      always_comb begin
        inc   = issue_acc && (issue_dst == PTR_W'(gi));
        sum   = SUM_W'(pending_reg[gi]) + SUM_W'(inc);
        under = 1'b0;
        nxt   = '0;
        if (sum < SUM_W'(count)) begin
          under = 1'b1;
        end else begin
          nxt = PEND_W'(sum - SUM_W'(count));
        end
      end

      assign win_valid[gi]    = hit;
      assign win_data[gi]     = data;
      assign cnt[gi]          = count;
      assign pending_next[gi] = nxt;
      assign underflow[gi]    = under;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Issue back-pressure. A completion to the same register this cycle frees
  // a slot, so the stall only fires when nothing is draining the counter.
  // ---------------------------------------------------------------------------
  assign issue_stall = issue_valid
                    && (pending_reg[issue_dst] == PEND_MAX)
                    && (cnt[issue_dst] == '0);
  assign issue_acc   = issue_valid && !issue_stall;

  // ---------------------------------------------------------------------------
  // Read ports: zero-latency, bypassing any same-cycle write (including the
  // R0 init). rd_busy looks at what is left outstanding after this cycle's
  // completions; a same-cycle issue deliberately does not show up here.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [PTR_W-1:0] ptr;
      assign ptr = rd_ptr[gi*PTR_W +: PTR_W];
      assign rd_data[gi*DATA_W +: DATA_W] = win_valid[ptr] ? win_data[ptr]
                                                          : regs_reg[ptr];
      assign rd_busy[gi] = SUM_W'(pending_reg[ptr]) > SUM_W'(cnt[ptr]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequential state. Reset drops all outstanding pending state, so writes
  // that were in flight at reset time later register as underflows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_RF) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_reg[i]    <= '0;
        pending_reg[i] <= '0;
      end
      busy_vec_reg      <= '0;
      err_underflow_reg <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (win_valid[i]) begin
          regs_reg[i] <= win_data[i];
        end
        pending_reg[i]  <= pending_next[i];
        busy_vec_reg[i] <= (pending_next[i] != '0);
      end
      if (|underflow) begin
        err_underflow_reg <= 1'b1;
      end
    end
  end

  assign busy_vec      = busy_vec_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_rf_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rf_scoreboard
//
// Directed bench for rf_scoreboard with default parameters (16x8, 3R/2W,
// 2-bit pending counters). Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_rf_scoreboard;

  localparam int PTR_W = 4;
  localparam int DW    = 8;

  logic          clk;
  logic          reset_RF;
  logic          init_R0;
  logic [7:0]    init_R0_data;
  logic [11:0]   rd_ptr;
  logic [23:0]   rd_data;
  logic [2:0]    rd_busy;
  logic          issue_valid;
  logic [3:0]    issue_dst;
  logic          issue_stall;
  logic [1:0]    wr_en;
  logic [7:0]    wr_ptr;
  logic [15:0]   wr_data;
  logic [15:0]   busy_vec;
  logic          err_underflow;

  int n_vec;
  int n_bad;

  rf_scoreboard dut (
    .clk           (clk),
    .reset_RF      (reset_RF),
    .init_R0       (init_R0),
    .init_R0_data  (init_R0_data),
    .rd_ptr        (rd_ptr),
    .rd_data       (rd_data),
    .rd_busy       (rd_busy),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_stall   (issue_stall),
    .wr_en         (wr_en),
    .wr_ptr        (wr_ptr),
    .wr_data       (wr_data),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_RF     = 1'b0;
    init_R0      = 1'b0;
    init_R0_data = '0;
    issue_valid  = 1'b0;
    issue_dst    = '0;
    wr_en        = '0;
    wr_ptr       = '0;
    wr_data      = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_RF = 1'b1;
    tick();
    reset_RF = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [3:0] p);
    rd_ptr[k*PTR_W +: PTR_W] = p;
  endtask

  task automatic set_wr(input int k, input logic [3:0] p, input logic [7:0] d);
    wr_en[k]                 = 1'b1;
    wr_ptr[k*PTR_W +: PTR_W] = p;
    wr_data[k*DW +: DW]      = d;
  endtask

  function automatic logic [7:0] rd(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rd_ptr = '0;
    idle();

    // ---- Reset state ----
    reset_RF = 1'b1;
    tick();
    tick();
    reset_RF = 1'b0;
    #1;
    check_val("rst_busy_vec", 32'(busy_vec), 32'h0);
    check_val("rst_err", 32'(err_underflow), 32'h0);
    check_val("rst_rd_busy", 32'(rd_busy), 32'h0);
    check_val("rst_stall", 32'(issue_stall), 32'h0);
    check_val("rst_rd0", 32'(rd(0)), 32'h0);

    // ---- Write R5 with bypass, then read back from the array ----
    set_wr(0, 4'd5, 8'h3C);
    set_rd(0, 4'd5);
    #1;
    check_val("byp_r5", 32'(rd(0)), 32'h3C);
    tick();
    idle();
    #1;
    check_val("arr_r5", 32'(rd(0)), 32'h3C);
    // nothing was pending on R5, so that completion is an underflow
    check_val("r5_underflow", 32'(err_underflow), 32'h1);

    // ---- Port conflict on R7 with pending[7]=1 ----
    do_reset();
    issue_valid = 1'b1;
    issue_dst   = 4'd7;
    tick();
    idle();
    #1;
    check_val("r7_busy_set", 32'(busy_vec[7]), 32'h1);
    set_wr(0, 4'd7, 8'hAA);
    set_wr(1, 4'd7, 8'h55);
    set_rd(1, 4'd7);
    #1;
    check_val("conf_byp", 32'(rd(1)), 32'hAA);
    check_val("conf_rd_busy", 32'(rd_busy[1]), 32'h0);
    tick();
    idle();
    #1;
    check_val("conf_arr", 32'(rd(1)), 32'hAA);
    check_val("conf_err", 32'(err_underflow), 32'h1);
    check_val("conf_busy7", 32'(busy_vec[7]), 32'h0);

    // ---- init_R0 beats write port 0 on R0 ----
    do_reset();
    init_R0      = 1'b1;
    init_R0_data = 8'h11;
    set_wr(0, 4'd0, 8'h22);
    set_rd(2, 4'd0);
    #1;
    check_val("init_byp", 32'(rd(2)), 32'h11);
    tick();
    idle();
    #1;
    check_val("init_arr", 32'(rd(2)), 32'h11);
    check_val("init_err", 32'(err_underflow), 32'h1);

    // ---- Saturation of pending[3] ----
    do_reset();
    set_rd(0, 4'd3);
    for (int n = 0; n < 3; n++) begin
      issue_valid = 1'b1;
      issue_dst   = 4'd3;
      #1;
      check_val($sformatf("iss3_%0d_stall", n), 32'(issue_stall), 32'h0);
      tick();
      idle();
      #1;
      check_val($sformatf("iss3_%0d_busy", n), 32'(busy_vec[3]), 32'h1);
    end
    check_val("sat_rd_busy", 32'(rd_busy[0]), 32'h1);
    // other destinations are unaffected by R3 saturation
    issue_valid = 1'b1;
    issue_dst   = 4'd2;
    #1;
    check_val("other_dst_stall", 32'(issue_stall), 32'h0);
    // 4th issue to R3 is refused
    issue_dst = 4'd3;
    #1;
    check_val("sat_stall", 32'(issue_stall), 32'h1);
    tick();
    // 4th issue with a same-cycle completion is accepted
    idle();
    issue_valid = 1'b1;
    issue_dst   = 4'd3;
    set_wr(0, 4'd3, 8'h01);
    #1;
    check_val("sat_wr_stall", 32'(issue_stall), 32'h0);
    check_val("sat_wr_rd_busy", 32'(rd_busy[0]), 32'h1);
    tick();
    idle();
    // counter must be exactly 3: drain with three completions
    for (int n = 0; n < 3; n++) begin
      set_wr(1, 4'd3, 8'(8'h40 + n));
      #1;
      check_val($sformatf("drain3_%0d_rd_busy", n), 32'(rd_busy[0]),
                (n == 2) ? 32'h0 : 32'h1);
      tick();
      idle();
      #1;
      check_val($sformatf("drain3_%0d_busy", n), 32'(busy_vec[3]),
                (n == 2) ? 32'h0 : 32'h1);
    end
    check_val("drain3_err", 32'(err_underflow), 32'h0);
    check_val("drain3_data", 32'(rd(0)), 32'h42);

    // ---- Issue R9 then complete it the next cycle ----
    issue_valid = 1'b1;
    issue_dst   = 4'd9;
    tick();
    idle();
    #1;
    check_val("r9_busy_set", 32'(busy_vec[9]), 32'h1);
    set_wr(1, 4'd9, 8'h5A);
    set_rd(1, 4'd9);
    #1;
    check_val("r9_rd_busy", 32'(rd_busy[1]), 32'h0);
    check_val("r9_byp", 32'(rd(1)), 32'h5A);
    tick();
    idle();
    #1;
    check_val("r9_busy_clr", 32'(busy_vec[9]), 32'h0);
    check_val("r9_err", 32'(err_underflow), 32'h0);

    // ---- Mid-flight reset with pending[4]=2 ----
    issue_valid = 1'b1;
    issue_dst   = 4'd4;
    tick();
    tick();
    idle();
    set_rd(0, 4'd4);
    #1;
    check_val("r4_busy", 32'(busy_vec[4]), 32'h1);
    check_val("r4_rd_busy", 32'(rd_busy[0]), 32'h1);
    do_reset();
    #1;
    check_val("mid_busy_vec", 32'(busy_vec), 32'h0);
    check_val("mid_r9_clr", 32'(rd(1)), 32'h0);
    check_val("mid_rd_busy", 32'(rd_busy[0]), 32'h0);
    set_wr(0, 4'd4, 8'h77);
    tick();
    idle();
    #1;
    check_val("mid_err", 32'(err_underflow), 32'h1);
    check_val("mid_r4_data", 32'(rd(0)), 32'h77);
    check_val("mid_busy_after", 32'(busy_vec), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised core register file: multiple read ports, multiple write ports and write-to-read bypass.
- Adds a per-register pending-write scoreboard that raises hazard flags for decode.
- Next-generation replacement for the fixed 16x3R1W file. Sits between decode (FD stage reads and issue) and writeback (MW stage results).
- Keeps the R0 init path used for core launch.

Parameters:
REG_COUNT, 16, number of architectural registers; power of two, at least 2
DATA_W, 8, register width in bits
RD_PORTS, 3, number of read ports
WR_PORTS, 2, number of write ports
PEND_W, 2, pending-write counter width per register; max outstanding writes = 2^PEND_W-1
(derived, not overridable) PTR_W = clog2(REG_COUNT)

Ports:
clk  in  1  clock
reset_RF  in  1  synchronous active-high reset
init_R0  in  1  load R0 with init_R0_data this cycle
init_R0_data  in  DATA_W  R0 init value
rd_ptr  in  RD_PORTS*PTR_W  read addresses; port k at bits [k*PTR_W +: PTR_W]
rd_data  out  RD_PORTS*DATA_W  read data, packed the same way
rd_busy  out  RD_PORTS  source k still has a write outstanding after this cycle
issue_valid  in  1  decode issues an instruction writing issue_dst
issue_dst  in  PTR_W  destination of the issued instruction
issue_stall  out  1  issue refused because the issue_dst counter is saturated
wr_en  in  WR_PORTS  write port enables
wr_ptr  in  WR_PORTS*PTR_W  write addresses
wr_data  in  WR_PORTS*DATA_W  write data
busy_vec  out  REG_COUNT  bit i = pending[i] != 0 (registered)
err_underflow  out  1  sticky: a write completed to a register with pending == 0

Behaviour:
- Reset: reset_RF at a posedge clears all registers, all pending counters and err_underflow to 0. Reset dominates init, writes and issue.
- Reset outputs: busy_vec=0 and err_underflow=0 the cycle after reset; rd_busy=0 and issue_stall=0 unless driven by same-cycle inputs.
- Write resolution per register, in priority order:
  - init_R0, for R0 only.
  - The lowest-index wr_en port addressing that register.
  - Otherwise hold.
  - Losing ports are discarded silently but still count as completions.
- Array update takes effect at the next posedge.
- Reads: combinational, zero latency.
  - rd_data[k] = the winning write value if any source writes rd_ptr[k] this cycle (bypass, including init_R0 for R0).
  - Otherwise rd_data[k] = the stored value.
- Completions per register: c[i] = number of asserted wr_en ports with wr_ptr == i. init_R0 is not a completion.
- Accepted issue: acc = issue_valid & !issue_stall.
- issue_stall = issue_valid & (pending[issue_dst] == 2^PEND_W-1) & (c[issue_dst] == 0). It is purely combinational; a write completing in the same cycle frees a slot.
- Counter update at the posedge, per register: next = pending + (acc & issue_dst==i) - c[i].
  - If next < 0: clamp to 0 and set err_underflow.
  - err_underflow clears only on reset.
- rd_busy[k] = (pending[rd_ptr[k]] - c[rd_ptr[k]]) > 0, with the subtraction clamped at 0. Same-cycle issue does not set rd_busy.
- busy_vec is a flop image of the counters (1-cycle latency).
- All widths are unsigned. Pointer compares are exactly PTR_W bits. No wrap-around on counters; they saturate via the stall and clamp rules.
- Reset mid-operation drops all outstanding pending state. Writes arriving later increment nothing and set err_underflow.

Test Plan:
- Reset, then wr_en=01, wr_ptr0=5, wr_data0=0x3C; same cycle rd_ptr0=5 -> rd_data0=0x3C (bypass); next cycle with wr_en=0 -> rd_data0=0x3C from array.
- Port conflict: wr_en=11, both ports ptr=7, data 0xAA/0x55 -> R7=0xAA; pending[7] decremented by 2, clamped, err_underflow=1 if pending was 1.
- init_R0=1, data=0x11, with wr port0 writing R0 data 0x22 -> R0=0x11; rd_ptr=0 same cycle reads 0x11.
- Issue dst=3 three times (PEND_W=2) -> busy_vec[3]=1 and pending=3; 4th issue -> issue_stall=1, counter stays 3; 4th issue with wr to R3 same cycle -> stall=0, counter stays 3.
- Issue dst=9, then write R9 the next cycle with rd_ptr=9 -> rd_busy=0 that cycle and rd_data=the write value; busy_vec[9]=0 the following cycle.
- Mid-flight reset with pending[4]=2 -> all counters 0 and registers 0; subsequent write to R4 -> err_underflow=1 and R4 updated.
